// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
// Load/compute/drain sequencer for the ROW_NUM x COL_NUM PE array of the conv
// unit. A job streams weights, ifmap and (optionally) ipsum words from the GLB
// into the array, runs a fixed-length COMPUTE window, then drains the opsums
// back to the GLB. Passes repeat until last_pass_i is seen on the final opsum
// beat. Every stream is valid/ready flow controlled; a phase ends after exactly
// N handshakes.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  job start pulse (accepted only while idle)
//   cfg_row_num_i            active rows, 1..ROW_NUM
//   cfg_col_num_i            active cols, 1..COL_NUM
//   cfg_ipsum_en_i           load ipsum each pass (else clear psums)
//   change_weight_i          on last opsum beat: next pass reloads weights
//   last_pass_i              on last opsum beat: job ends after this pass
//   glb_rvalid_i/glb_rready_o/glb_rdata_i   GLB read stream
//   glb_wvalid_o/glb_wready_i/glb_wdata_o   opsum write stream to GLB
//   pe_wdata_o               data to PE array (0 unless a write strobe is set)
//   pe_wgt_we_o/pe_ifm_we_o/pe_ips_we_o     PE write strobes
//   pe_idx_o                 beat index inside the current phase
//   pe_psum_clr_o            zero PE psums (ipsum pass skipped)
//   pe_compute_en_o          high during every COMPUTE cycle
//   pe_opsum_rd_o            opsum word consumed by the GLB
//   pe_opsum_i               opsum word selected by pe_idx_o
//   busy_o, done_o, cfg_err_o status
// ---------------------------------------------------------------------------
module conv_seq_ctrl #(
    parameter int ROW_NUM     = 32,
    parameter int COL_NUM     = 32,
    parameter int DATA_W      = 32,
    parameter int WGT_WPR     = 8,
    parameter int PSUM_WPR    = 2,
    parameter int COMPUTE_CYC = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [$clog2(ROW_NUM+1)-1:0]     cfg_row_num_i,
    input  logic [$clog2(COL_NUM+1)-1:0]     cfg_col_num_i,
    input  logic                             cfg_ipsum_en_i,
    input  logic                             change_weight_i,
    input  logic                             last_pass_i,
    input  logic                             glb_rvalid_i,
    output logic                             glb_rready_o,
    input  logic [DATA_W-1:0]                glb_rdata_i,
    output logic                             glb_wvalid_o,
    input  logic                             glb_wready_i,
    output logic [DATA_W-1:0]                glb_wdata_o,
    output logic [DATA_W-1:0]                pe_wdata_o,
    output logic                             pe_wgt_we_o,
    output logic                             pe_ifm_we_o,
    output logic                             pe_ips_we_o,
    output logic [7:0]                       pe_idx_o,
    output logic                             pe_psum_clr_o,
    output logic                             pe_compute_en_o,
    output logic                             pe_opsum_rd_o,
    input  logic [DATA_W-1:0]                pe_opsum_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             cfg_err_o
);

    localparam int RW  = $clog2(ROW_NUM + 1);
    localparam int CW  = $clog2(COL_NUM + 1);
    localparam int CCW = $clog2(COMPUTE_CYC + 1);

    localparam logic [RW-1:0]  ROW_MAX   = RW'(ROW_NUM);
    localparam logic [CW-1:0]  COL_MAX   = CW'(COL_NUM);
    localparam logic [CCW-1:0] COMP_LAST = CCW'(COMPUTE_CYC - 1);

    // Beat counts must fit the 8-bit counter (N-1 <= 255).
    if (ROW_NUM * WGT_WPR > 256 || ROW_NUM * PSUM_WPR > 256 || COL_NUM > 256 ||
        COMPUTE_CYC < 1) begin : g_param_check
        $error("conv_seq_ctrl: parameters exceed the 8-bit beat counter range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WGT_LOAD,
        S_IFM_LOAD,
        S_IPS_LOAD,
        S_COMPUTE,
        S_OPS_OUT
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [CCW-1:0] compCnt_q, compCnt_d;
    logic [RW-1:0]  rows_q, rows_d;
    logic [CW-1:0]  cols_q, cols_d;
    logic           ipsEn_q, ipsEn_d;

    logic [8:0]     nBeats;
    logic           isLoad;
    logic           rBeat;
    logic           wBeat;
    logic           lastBeat;
    logic           cfgOk;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            compCnt_q <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            ipsEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            compCnt_q <= compCnt_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            ipsEn_q   <= ipsEn_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        compCnt_d       = compCnt_q;
        rows_d          = rows_q;
        cols_d          = cols_q;
        ipsEn_d         = ipsEn_q;
        pe_wgt_we_o     = 1'b0;
        pe_ifm_we_o     = 1'b0;
        pe_ips_we_o     = 1'b0;
        pe_psum_clr_o   = 1'b0;
        pe_compute_en_o = 1'b0;
        glb_wvalid_o    = 1'b0;
        done_o          = 1'b0;
        cfg_err_o       = 1'b0;

        // Phase length from the configuration latched at start.
        case (state_q)
            S_WGT_LOAD:           nBeats = 9'(rows_q) * 9'(WGT_WPR);
            S_IFM_LOAD:           nBeats = 9'(cols_q);
            S_IPS_LOAD, S_OPS_OUT: nBeats = 9'(rows_q) * 9'(PSUM_WPR);
            default:              nBeats = 9'd1;
        endcase

        isLoad   = (state_q == S_WGT_LOAD) || (state_q == S_IFM_LOAD) ||
                   (state_q == S_IPS_LOAD);
        rBeat    = isLoad && glb_rvalid_i;
        wBeat    = (state_q == S_OPS_OUT) && glb_wready_i;
        lastBeat = (rBeat || wBeat) && ({1'b0, cnt_q} == nBeats - 9'd1);
        cfgOk    = (cfg_row_num_i != '0) && (cfg_row_num_i <= ROW_MAX) &&
                   (cfg_col_num_i != '0) && (cfg_col_num_i <= COL_MAX);

        // The counter only moves on a handshake and wraps to 0 on the
        // last beat, so every phase starts at index 0.
        if (rBeat || wBeat) begin
            cnt_d = lastBeat ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfgOk) begin
                        rows_d  = cfg_row_num_i;
                        cols_d  = cfg_col_num_i;
                        ipsEn_d = cfg_ipsum_en_i;
                        state_d = S_WGT_LOAD;
                    end else begin
                        cfg_err_o = 1'b1;
                    end
                end
            end
            S_WGT_LOAD: begin
                pe_wgt_we_o = rBeat;
                if (lastBeat) state_d = S_IFM_LOAD;
            end
            S_IFM_LOAD: begin
                pe_ifm_we_o = rBeat;
                if (lastBeat) begin
                    if (ipsEn_q) begin
                        state_d = S_IPS_LOAD;
                    end else begin
                        pe_psum_clr_o = 1'b1;
                        state_d       = S_COMPUTE;
                    end
                end
            end
            S_IPS_LOAD: begin
                pe_ips_we_o = rBeat;
                if (lastBeat) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                pe_compute_en_o = 1'b1;
                if (compCnt_q == COMP_LAST) begin
                    compCnt_d = '0;
                    state_d   = S_OPS_OUT;
                end else begin
                    compCnt_d = compCnt_q + 1'b1;
                end
            end
            S_OPS_OUT: begin
                glb_wvalid_o = 1'b1;
                // last_pass wins over change_weight on the final beat.
                if (lastBeat) begin
                    if (last_pass_i) begin
                        done_o  = 1'b1;
                        state_d = S_IDLE;
                    end else if (change_weight_i) begin
                        state_d = S_WGT_LOAD;
                    end else begin
                        state_d = S_IFM_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Data paths are gated so every output is 0 while idle or in reset.
    // glb_wdata follows pe_opsum, which is stable while pe_idx is held.
    always_comb begin
        glb_rready_o  = isLoad;
        pe_opsum_rd_o = wBeat;
        pe_idx_o      = cnt_q;
        busy_o        = (state_q != S_IDLE);
        glb_wdata_o   = glb_wvalid_o ? pe_opsum_i : '0;
        pe_wdata_o    = (pe_wgt_we_o || pe_ifm_we_o || pe_ips_we_o) ? glb_rdata_i : '0;
    end

endmodule
